uart_rx_fsm: RTL and testbench
==============================

Name: uart_rx_fsm

Overview:
Receive-side controller for the UART RX path. It sequences the majority-vote data-sampling block by driving its data_samp_en and edge_cnt inputs. It consumes the resulting sampled_bit at each bit boundary and deserializes the frame (start, DATA_WIDTH data bits LSB-first, optional parity, stop). It reports the received byte and the frame status to the downstream consumer.

Parameters:
DATA_WIDTH, 8, number of data bits per frame.

Ports:
clk  input  1  system clock, oversampling rate.
ARSTn  input  1  reset; synchronous, active-low.
RX_IN  input  1  serial line, idle high.
prescale  input  5  oversampling ratio; supported values 8 and 16.
PAR_EN  input  1  1 = frame carries a parity bit.
PAR_TYP  input  1  0 = even parity, 1 = odd parity.
sampled_bit  input  1  majority-voted bit returned by the sampler.
data_samp_en  output  1  sampler enable.
edge_cnt  output  5  oversample edge index within the current bit.
P_DATA  output  DATA_WIDTH  last good received word.
data_valid  output  1  one-cycle pulse when P_DATA is updated.
par_err  output  1  one-cycle parity-error pulse at frame end.
stp_err  output  1  one-cycle stop-error pulse at frame end.
strt_glitch  output  1  one-cycle pulse on a false start.

Behaviour:
- Reset: ARSTn sampled low on a clk edge forces the following, regardless of current state (mid-frame included):
  - state to IDLE;
  - edge_cnt, bit counter, shift register, P_DATA and internal error flags to 0;
  - all outputs to 0.
- States: IDLE, START, DATA, PARITY, STOP. data_samp_en = 1 exactly in START, DATA, PARITY and STOP.
- Config latch: in the detect cycle (IDLE with RX_IN = 0), latch prescale, PAR_EN and PAR_TYP. These latched values are held for the whole frame, so mid-frame input changes are ignored. A latched prescale < 4 is replaced by 8. Values other than 8 and 16 are unsupported, but the counter still wraps at latched prescale - 1.
- Edge counter:
  - IDLE: edge_cnt = 0.
  - Detect cycle counts as edge 0. On that clk edge: state goes to START, edge_cnt goes to 1.
  - Outside IDLE: edge_cnt increments every cycle and wraps to 0 after the value P-1, where P is the latched prescale.
  - Boundary cycle: the cycle in which edge_cnt == P-1. sampled_bit is consumed only in boundary cycles, because the sampler output is valid only for edge_cnt > P/2.
- START boundary:
  - sampled_bit = 0: go to DATA, bit counter = 0.
  - sampled_bit = 1: go to IDLE and pulse strt_glitch for one cycle, registered.
- DATA boundary:
  - Shift right, with sampled_bit entering the MSB (LSB-first line order).
  - Increment the bit counter.
  - After the DATA_WIDTH-th bit: go to PARITY if PAR_EN, otherwise go to STOP.
- PARITY boundary:
  - Expected parity = XOR of the data bits (even) or its inverse (odd).
  - Set the internal par flag if sampled_bit differs from the expected parity.
  - Go to STOP.
- STOP boundary: go to IDLE. On the next cycle, registered:
  - stp_err = 1 if sampled_bit = 0.
  - par_err = 1 if the par flag is set.
  - If neither error: P_DATA <= shift register and data_valid = 1.
  - If either error: P_DATA holds its old value and data_valid = 0.
  - The par flag is cleared.
- Latency: frame length F = 1 + DATA_WIDTH + PAR_EN + 1 bits.
  - The last boundary occurs at cycle F*P - 1, counting the detect cycle as cycle 0.
  - Status pulses occur at cycle F*P.
  - A new start can be detected in that same cycle F*P (back-to-back frames).
- P_DATA is stable between data_valid pulses. At most one of data_valid and the error pulses fires per frame, except that par_err and stp_err may fire together.

Test Plan:
1. prescale = 8, PAR_EN = 0; frame 0x A5 sent LSB-first -> data_valid pulse at cycle 80 after the detect cycle, P_DATA = 0xA5, par_err = stp_err = 0.
2. prescale = 8, PAR_EN = 1, PAR_TYP = 0; 0x 0F with parity bit 1 (wrong) -> par_err pulse at cycle 88, data_valid = 0, P_DATA unchanged.
3. prescale = 16, PAR_EN = 1, PAR_TYP = 1; 0x 3C with parity 1, stop bit = 0 -> stp_err = 1 at cycle 176, par_err = 0, data_valid = 0.
4. RX_IN low for 2 cycles only, then high, prescale = 8 -> strt_glitch pulse at cycle 8, state IDLE, data_samp_en = 0 from cycle 8 onward.
5. Two back-to-back frames 0x 55 then 0x AA with no idle gap -> two data_valid pulses 80 cycles apart, P_DATA = 0x55 then 0xAA. Toggling prescale and PAR_EN mid-frame has no effect on either frame.
6. ARSTn low for 1 cycle during DATA bit 3 -> next cycle state IDLE and all outputs 0. A subsequent clean frame 0x 81 is received correctly.

Source files
------------

// File: rtl/uart_rx_fsm_if.sv
// Sampler/consumer bus of the UART RX controller.
// master: the RX FSM (drives the sampler controls and the result/status signals).
// slave:  the sampler and the downstream consumer viewed as a single peer.
interface uart_rx_fsm_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  data_samp_en;
    logic [4:0]            edge_cnt;
    logic                  sampled_bit;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;
    logic                  strt_glitch;

    modport master (
        output data_samp_en, edge_cnt, P_DATA, data_valid, par_err, stp_err, strt_glitch,
        input  sampled_bit
    );

    modport slave (
        input  data_samp_en, edge_cnt, P_DATA, data_valid, par_err, stp_err, strt_glitch,
        output sampled_bit
    );
endinterface

// File: rtl/uart_rx_fsm.sv
// UART RX controller: sequences the oversampling sampler and deserializes
// start / data (LSB first) / optional parity / stop into P_DATA with status pulses.
module uart_rx_fsm #(
    parameter int DATA_WIDTH = 8
) (
    input  logic          clk,
    input  logic          ARSTn,
    input  logic          RX_IN,
    input  logic [4:0]    prescale,
    input  logic          PAR_EN,
    input  logic          PAR_TYP,
    uart_rx_fsm_if.master rx_bus
);
    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state_reg, state_next;
    logic [4:0]            edge_reg, edge_next;
    logic [4:0]            p_reg, p_next;
    logic                  par_en_reg, par_en_next;
    logic                  par_typ_reg, par_typ_next;
    logic [CW-1:0]         bit_reg, bit_next;
    logic [DATA_WIDTH-1:0] shift_reg, shift_next;
    logic [DATA_WIDTH-1:0] pdata_reg, pdata_next;
    logic                  par_flag_reg, par_flag_next;
    logic                  valid_reg, valid_next;
    logic                  par_err_reg, par_err_next;
    logic                  stp_err_reg, stp_err_next;
    logic                  glitch_reg, glitch_next;

    logic [4:0]            p_last;
    logic                  boundary;
    logic [DATA_WIDTH-1:0] shifted;

    // Sampler output is only trustworthy in the last oversample edge of a bit.
    assign p_last   = p_reg - 5'd1;
    assign boundary = (state_reg != IDLE) && (edge_reg == p_last);

    // Shift-right image of the data register with the new bit entering the MSB.
    generate
        for (genvar gi = 0; gi < DATA_WIDTH - 1; gi++) begin : g_shift
            assign shifted[gi] = shift_reg[gi + 1];
        end
    endgenerate
    assign shifted[DATA_WIDTH-1] = rx_bus.sampled_bit;

    // Next-state, counters, frame config latch and status pulse generation.
    always_comb begin
        state_next    = state_reg;
        edge_next     = edge_reg;
        p_next        = p_reg;
        par_en_next   = par_en_reg;
        par_typ_next  = par_typ_reg;
        bit_next      = bit_reg;
        shift_next    = shift_reg;
        pdata_next    = pdata_reg;
        par_flag_next = par_flag_reg;
        valid_next    = 1'b0;
        par_err_next  = 1'b0;
        stp_err_next  = 1'b0;
        glitch_next   = 1'b0;

        if (state_reg != IDLE) begin
            edge_next = boundary ? 5'd0 : edge_reg + 5'd1;
        end

        case (state_reg)
            IDLE: begin
                edge_next = 5'd0;
                if (!RX_IN) begin
                    // Detect cycle is edge 0; config is frozen for the whole frame.
                    state_next   = START;
                    edge_next    = 5'd1;
                    p_next       = (prescale < 5'd4) ? 5'd8 : prescale;
                    par_en_next  = PAR_EN;
                    par_typ_next = PAR_TYP;
                end
            end
            START: begin
                if (boundary) begin
                    if (!rx_bus.sampled_bit) begin
                        state_next = DATA;
                        bit_next   = '0;
                    end else begin
                        state_next  = IDLE;
                        glitch_next = 1'b1;
                    end
                end
            end
            DATA: begin
                if (boundary) begin
                    shift_next = shifted;
                    bit_next   = bit_reg + 1'b1;
                    if (bit_reg == LAST_BIT) begin
                        state_next = par_en_reg ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (boundary) begin
                    par_flag_next = rx_bus.sampled_bit ^ (^shift_reg) ^ par_typ_reg;
                    state_next    = STOP;
                end
            end
            STOP: begin
                if (boundary) begin
                    state_next    = IDLE;
                    stp_err_next  = ~rx_bus.sampled_bit;
                    par_err_next  = par_flag_reg;
                    par_flag_next = 1'b0;
                    if (rx_bus.sampled_bit && !par_flag_reg) begin
                        pdata_next = shift_reg;
                        valid_next = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!ARSTn) begin
            state_reg    <= IDLE;
            edge_reg     <= 5'd0;
            p_reg        <= 5'd0;
            par_en_reg   <= 1'b0;
            par_typ_reg  <= 1'b0;
            bit_reg      <= '0;
            shift_reg    <= '0;
            pdata_reg    <= '0;
            par_flag_reg <= 1'b0;
            valid_reg    <= 1'b0;
            par_err_reg  <= 1'b0;
            stp_err_reg  <= 1'b0;
            glitch_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            edge_reg     <= edge_next;
            p_reg        <= p_next;
            par_en_reg   <= par_en_next;
            par_typ_reg  <= par_typ_next;
            bit_reg      <= bit_next;
            shift_reg    <= shift_next;
            pdata_reg    <= pdata_next;
            par_flag_reg <= par_flag_next;
            valid_reg    <= valid_next;
            par_err_reg  <= par_err_next;
            stp_err_reg  <= stp_err_next;
            glitch_reg   <= glitch_next;
        end
    end

    assign rx_bus.data_samp_en = (state_reg != IDLE);
    assign rx_bus.edge_cnt     = edge_reg;
    assign rx_bus.P_DATA       = pdata_reg;
    assign rx_bus.data_valid   = valid_reg;
    assign rx_bus.par_err      = par_err_reg;
    assign rx_bus.stp_err      = stp_err_reg;
    assign rx_bus.strt_glitch  = glitch_reg;
endmodule

// File: tb/tb_uart_rx_fsm.sv
// Testbench for uart_rx_fsm: frame-level reference model with randomized
// sampler noise between bit boundaries and randomized mid-frame config changes.
module tb_uart_rx_fsm;
    logic       clk;
    logic       ARSTn;
    logic       RX_IN;
    logic [4:0] prescale;
    logic       PAR_EN;
    logic       PAR_TYP;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_pdata = 8'h00;

    uart_rx_fsm_if #(.DATA_WIDTH(8)) bus ();

    uart_rx_fsm #(.DATA_WIDTH(8)) dut (
        .clk      (clk),
        .ARSTn    (ARSTn),
        .RX_IN    (RX_IN),
        .prescale (prescale),
        .PAR_EN   (PAR_EN),
        .PAR_TYP  (PAR_TYP),
        .rx_bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drives one frame cycle by cycle (inputs 1 time unit after posedge, checks at negedge).
    // Cycle 0 is the detect cycle; cycle F*P is the status cycle, which may also be the
    // detect cycle of a chained frame. abort_at >= 0 pulses ARSTn in that cycle instead.
    task automatic run_frame(input string tag, input logic [7:0] data, input int p_in,
                             input bit pen, input bit ptyp, input bit par_bad, input bit stop_bit,
                             input bit skip_detect, input bit next_start, input int next_p,
                             input bit next_pen, input bit next_ptyp, input int abort_at);
        int   p, f, last;
        logic line [0:10];
        bit   perr, serr, good;
        logic exp_en, exp_valid, exp_perr, exp_serr;
        logic [4:0] exp_edge;

        p    = (p_in < 4) ? 8 : p_in;
        f    = 10 + (pen ? 1 : 0);
        last = f * p;
        line[0] = 1'b0;
        for (int i = 0; i < 8; i++) line[i + 1] = data[i];
        if (pen) line[9] = (^data) ^ ptyp ^ par_bad;
        line[f - 1] = stop_bit;
        perr = pen && par_bad;
        serr = !stop_bit;
        good = !perr && !serr;

        for (int c = (skip_detect ? 1 : 0); c <= last; c++) begin
            if (c < last) begin
                RX_IN = line[c / p];
                bus.sampled_bit = ((c % p) == p - 1) ? line[c / p] : 1'($urandom_range(0, 1));
                if (c == 0) begin
                    prescale = 5'(p_in);
                    PAR_EN   = pen;
                    PAR_TYP  = ptyp;
                end else begin
                    prescale = 5'($urandom_range(0, 31));
                    PAR_EN   = 1'($urandom_range(0, 1));
                    PAR_TYP  = 1'($urandom_range(0, 1));
                end
                if (c == abort_at) ARSTn = 1'b0;
            end else begin
                bus.sampled_bit = 1'($urandom_range(0, 1));
                RX_IN = next_start ? 1'b0 : 1'b1;
                if (next_start) begin
                    prescale = 5'(next_p);
                    PAR_EN   = next_pen;
                    PAR_TYP  = next_ptyp;
                end
            end

            @(negedge clk);
            exp_en    = (c >= 1) && (c < last);
            exp_edge  = (c < last) ? 5'(c % p) : 5'd0;
            exp_valid = (c == last) && good;
            exp_perr  = (c == last) && perr;
            exp_serr  = (c == last) && serr;
            if (exp_valid) exp_pdata = data;

            checks++;
            if (bus.data_samp_en !== exp_en) begin
                errors++;
                $display("FAIL %s c=%0d data_samp_en got %b expected %b", tag, c, bus.data_samp_en, exp_en);
            end
            checks++;
            if (bus.edge_cnt !== exp_edge) begin
                errors++;
                $display("FAIL %s c=%0d edge_cnt got %0d expected %0d", tag, c, bus.edge_cnt, exp_edge);
            end
            checks++;
            if (bus.data_valid !== exp_valid) begin
                errors++;
                $display("FAIL %s c=%0d data_valid got %b expected %b", tag, c, bus.data_valid, exp_valid);
            end
            checks++;
            if (bus.par_err !== exp_perr) begin
                errors++;
                $display("FAIL %s c=%0d par_err got %b expected %b", tag, c, bus.par_err, exp_perr);
            end
            checks++;
            if (bus.stp_err !== exp_serr) begin
                errors++;
                $display("FAIL %s c=%0d stp_err got %b expected %b", tag, c, bus.stp_err, exp_serr);
            end
            checks++;
            if (bus.strt_glitch !== 1'b0) begin
                errors++;
                $display("FAIL %s c=%0d strt_glitch got %b expected 0", tag, c, bus.strt_glitch);
            end
            checks++;
            if (bus.P_DATA !== exp_pdata) begin
                errors++;
                $display("FAIL %s c=%0d P_DATA got %h expected %h", tag, c, bus.P_DATA, exp_pdata);
            end

            @(posedge clk);
            #1;
            if (c == abort_at) begin
                ARSTn = 1'b1;
                RX_IN = 1'b1;
                exp_pdata = 8'h00;
                @(negedge clk);
                checks++;
                if ({bus.data_samp_en, bus.edge_cnt, bus.data_valid, bus.par_err, bus.stp_err,
                     bus.strt_glitch, bus.P_DATA} !== 18'd0) begin
                    errors++;
                    $display("FAIL %s after reset outputs got en=%b edge=%0d v=%b pe=%b se=%b g=%b pd=%h expected all 0",
                             tag, bus.data_samp_en, bus.edge_cnt, bus.data_valid, bus.par_err,
                             bus.stp_err, bus.strt_glitch, bus.P_DATA);
                end
                @(posedge clk);
                #1;
                $display("frame %s data=%h aborted by reset at cycle %0d", tag, data, c);
                return;
            end
        end
        $display("frame %s data=%h P=%0d par_en=%0d par_typ=%0d -> valid=%0d par_err=%0d stp_err=%0d",
                 tag, data, p, pen, ptyp, good, perr, serr);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            ARSTn = 1'b0;
            RX_IN = (i == 0) ? 1'b1 : 1'b0;
            bus.sampled_bit = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if ({bus.data_samp_en, bus.edge_cnt, bus.data_valid, bus.par_err, bus.stp_err,
                 bus.strt_glitch, bus.P_DATA} !== 18'd0) begin
                errors++;
                $display("FAIL reset cycle %0d outputs got en=%b edge=%0d pd=%h expected all 0",
                         i, bus.data_samp_en, bus.edge_cnt, bus.P_DATA);
            end
            @(posedge clk);
            #1;
        end
        ARSTn = 1'b1;
        RX_IN = 1'b1;
        @(posedge clk);
        #1;
        $display("reset held 4 cycles with line low, outputs idle");
    endtask

    task automatic test_basic();
        run_frame("basic", 8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8, 1'b0, 1'b0, -1);
    endtask

    task automatic test_parity_error();
        run_frame("parity_err", 8'h0F, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8, 1'b0, 1'b0, -1);
    endtask

    task automatic test_stop_error();
        run_frame("stop_err", 8'h3C, 16, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8, 1'b0, 1'b0, -1);
    endtask

    task automatic test_glitch();
        logic       exp_en, exp_g;
        logic [4:0] exp_edge;
        for (int c = 0; c <= 12; c++) begin
            RX_IN = (c < 2) ? 1'b0 : 1'b1;
            bus.sampled_bit = (c == 7) ? 1'b1 : 1'($urandom_range(0, 1));
            prescale = (c == 0) ? 5'd8 : 5'($urandom_range(0, 31));
            PAR_EN   = 1'($urandom_range(0, 1));
            PAR_TYP  = 1'($urandom_range(0, 1));
            @(negedge clk);
            exp_en   = (c >= 1) && (c <= 7);
            exp_g    = (c == 8);
            exp_edge = exp_en ? 5'(c) : 5'd0;
            checks++;
            if (bus.data_samp_en !== exp_en) begin
                errors++;
                $display("FAIL glitch c=%0d data_samp_en got %b expected %b", c, bus.data_samp_en, exp_en);
            end
            checks++;
            if (bus.strt_glitch !== exp_g) begin
                errors++;
                $display("FAIL glitch c=%0d strt_glitch got %b expected %b", c, bus.strt_glitch, exp_g);
            end
            checks++;
            if (bus.edge_cnt !== exp_edge) begin
                errors++;
                $display("FAIL glitch c=%0d edge_cnt got %0d expected %0d", c, bus.edge_cnt, exp_edge);
            end
            checks++;
            if ({bus.data_valid, bus.par_err, bus.stp_err} !== 3'b000 || bus.P_DATA !== exp_pdata) begin
                errors++;
                $display("FAIL glitch c=%0d status got v=%b pe=%b se=%b pd=%h expected 0 0 0 %h",
                         c, bus.data_valid, bus.par_err, bus.stp_err, bus.P_DATA, exp_pdata);
            end
            @(posedge clk);
            #1;
        end
        $display("glitch: line low 2 cycles at P=8 -> strt_glitch at cycle 8");
    endtask

    task automatic test_back_to_back();
        run_frame("b2b_0", 8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8, 1'b0, 1'b0, -1);
        run_frame("b2b_1", 8'hAA, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8, 1'b0, 1'b0, -1);
    endtask

    task automatic test_mid_reset();
        run_frame("mid_reset", 8'hC3, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8, 1'b0, 1'b0, 4 * 8 + 3);
        run_frame("after_reset", 8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8, 1'b0, 1'b0, -1);
    endtask

    task automatic test_random();
        localparam int N = 16;
        logic [7:0] d   [N];
        int         p   [N];
        bit         pen [N], ptyp [N], pbad [N], stp [N], chain [N];
        for (int i = 0; i < N; i++) begin
            d[i]     = 8'($urandom_range(0, 255));
            case ($urandom_range(0, 3))
                0: p[i] = 16;
                1: p[i] = $urandom_range(0, 3);
                default: p[i] = 8;
            endcase
            pen[i]   = 1'($urandom_range(0, 1));
            ptyp[i]  = 1'($urandom_range(0, 1));
            pbad[i]  = ($urandom_range(0, 3) == 0);
            stp[i]   = ($urandom_range(0, 4) != 0);
            chain[i] = (i > 0) && ($urandom_range(0, 1) == 1);
        end
        for (int i = 0; i < N; i++) begin
            bit nxt;
            nxt = (i < N - 1) ? chain[i + 1] : 1'b0;
            run_frame($sformatf("rand%0d", i), d[i], p[i], pen[i], ptyp[i], pbad[i], stp[i],
                      chain[i], nxt, (i < N - 1) ? p[i + 1] : 8,
                      (i < N - 1) ? pen[i + 1] : 1'b0, (i < N - 1) ? ptyp[i + 1] : 1'b0, -1);
        end
    endtask

    initial begin
        ARSTn = 1'b0;
        RX_IN = 1'b1;
        prescale = 5'd8;
        PAR_EN = 1'b0;
        PAR_TYP = 1'b0;
        bus.sampled_bit = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_parity_error();
        test_stop_error();
        test_glitch();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
